// File: rtl/uart_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_if
// Description : Byte stream in from uart_rx and config-write/error results out
//               of the command controller. The controller takes the slave view.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_cfg_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        cfg_we_o;
    logic [7:0]  cfg_addr_o;
    logic [15:0] cfg_data_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        busy_o;

    modport slave (
        input  rx_data_i,
        input  rx_valid_i,
        output cfg_we_o,
        output cfg_addr_o,
        output cfg_data_o,
        output err_o,
        output err_code_o,
        output busy_o
    );

    modport master (
        output rx_data_i,
        output rx_valid_i,
        input  cfg_we_o,
        input  cfg_addr_o,
        input  cfg_data_o,
        input  err_o,
        input  err_code_o,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_ctrl
// Description : Frames the uart_rx byte stream (SYNC, ADDR, DATA_HI, DATA_LO,
//               CSUM) into register-write commands; bad or stalled frames are
//               dropped with a one-cycle error pulse and a held error code.
// Revision    : 1.0  initial release
// ============================================================================
module uart_cfg_ctrl #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         NUM_REGS    = 4,
    parameter int         TIMEOUT_CYC = 64
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_cfg_if.slave  bus
);

    localparam int              CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]      NUM_REGS_W = 9'(NUM_REGS);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ADDR    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [7:0]       csum_q, csum_d;
    logic             we_q, we_d;
    logic [7:0]       out_addr_q, out_addr_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    // State, frame capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // Next-state: frame sequencing, inter-byte stall detection and verdict.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;
        code_d     = code_q;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (bus.rx_valid_i && (bus.rx_data_i == SYNC_BYTE)) begin
                state_d = S_ADDR;
            end
        end else if (bus.rx_valid_i) begin
            // A byte landing on the last allowed cycle still counts.
            cnt_d = '0;
            unique case (state_q)
                S_ADDR: begin
                    addr_d  = bus.rx_data_i;
                    csum_d  = bus.rx_data_i;
                    state_d = S_DHI;
                end
                S_DHI: begin
                    data_d[15:8] = bus.rx_data_i;
                    csum_d       = csum_q ^ bus.rx_data_i;
                    state_d      = S_DLO;
                end
                S_DLO: begin
                    data_d[7:0] = bus.rx_data_i;
                    csum_d      = csum_q ^ bus.rx_data_i;
                    state_d     = S_CSUM;
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (bus.rx_data_i != csum_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end else if ({1'b0, addr_q} >= NUM_REGS_W) begin
                        err_d  = 1'b1;
                        code_d = ERR_ADDR;
                    end else begin
                        we_d       = 1'b1;
                        out_addr_d = addr_q;
                        out_data_d = data_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.cfg_we_o   = we_q;
    assign bus.cfg_addr_o = out_addr_q;
    assign bus.cfg_data_o = out_data_q;
    assign bus.err_o      = err_q;
    assign bus.err_code_o = code_q;
    assign bus.busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cfg_ctrl
// Description : Self-checking bench for uart_cfg_ctrl with a frame-level
//               reference model and randomized byte streams.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cfg_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int NREGS = 4;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cfg_if bus ();

    uart_cfg_ctrl #(.SYNC_BYTE(SYNC), .NUM_REGS(NREGS), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: collected frame bytes and idle cycles since last byte.
    logic [7:0]  frame_q[$];
    bit          in_frame = 0;
    int          gap = 0;
    logic        m_we = 0, m_err = 0, m_busy = 0;
    logic [7:0]  m_addr = 0;
    logic [15:0] m_data = 0;
    logic [1:0]  m_code = 0;
    int          m_we_cnt = 0, m_err_cnt = 0;

    always @(posedge clk) begin
        m_we  = 0;
        m_err = 0;
        if (rst) begin
            in_frame = 0; gap = 0; frame_q.delete();
            m_addr = 0; m_data = 0; m_code = 0;
        end else if (!in_frame) begin
            if (bus.rx_valid_i && bus.rx_data_i == SYNC) begin
                in_frame = 1; gap = 0; frame_q.delete();
            end
        end else if (bus.rx_valid_i) begin
            frame_q.push_back(bus.rx_data_i);
            gap = 0;
            if (frame_q.size() == 4) begin
                in_frame = 0;
                if ((frame_q[0] ^ frame_q[1] ^ frame_q[2]) != frame_q[3]) begin
                    m_err = 1; m_code = 1; m_err_cnt++;
                end else if (int'(frame_q[0]) >= NREGS) begin
                    m_err = 1; m_code = 3; m_err_cnt++;
                end else begin
                    m_we = 1; m_we_cnt++;
                    m_addr = frame_q[0];
                    m_data = {frame_q[1], frame_q[2]};
                end
            end
        end else begin
            gap++;
            if (gap == TMO) begin
                in_frame = 0; m_err = 1; m_code = 2; m_err_cnt++;
            end
        end
        m_busy = in_frame;
    end

    // Cycle-by-cycle monitor against the model; tasks inspect the tallies.
    bit mon_en = 0;
    int mm = 0, obs_we = 0, obs_err = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cfg_we_o !== m_we || bus.err_o !== m_err || bus.busy_o !== m_busy ||
                bus.cfg_addr_o !== m_addr || bus.cfg_data_o !== m_data || bus.err_code_o !== m_code)
                mm++;
            if (bus.cfg_we_o === 1'b1) obs_we++;
            if (bus.err_o === 1'b1) obs_err++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid_i = 0;
            bus.rx_data_i  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int g);
        idle(g);
        bus.rx_valid_i = 1;
        bus.rx_data_i  = b;
        @(negedge clk);
        bus.rx_valid_i = 0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                              input bit corrupt, input int g);
        logic [7:0] cs;
        cs = a ^ hi ^ lo;
        if (corrupt) cs = cs ^ 8'(1 << $urandom_range(0, 7));
        send_byte(SYNC, g); send_byte(a, g); send_byte(hi, g); send_byte(lo, g); send_byte(cs, g);
    endtask

    task automatic test_reset;
        checks++; if (bus.cfg_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.cfg_we_o); end
        checks++; if (bus.cfg_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.cfg_addr_o); end
        checks++; if (bus.cfg_data_o !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.cfg_data_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_o); end
        checks++; if (bus.err_code_o !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", bus.err_code_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_good_frame;
        int we0, er0, mm0;
        we0 = obs_we; er0 = obs_err; mm0 = mm;
        send_byte(8'hA5, 10); send_byte(8'h02, 10); send_byte(8'h12, 10);
        send_byte(8'h34, 10); send_byte(8'h24, 10);
        idle(3);
        checks++; if (obs_we - we0 !== 1) begin errors++; $display("FAIL good_we_count got %0d want 1", obs_we - we0); end
        checks++; if (obs_err - er0 !== 0) begin errors++; $display("FAIL good_err_count got %0d want 0", obs_err - er0); end
        checks++; if (bus.cfg_addr_o !== 8'h02) begin errors++; $display("FAIL good_addr got %h want 02", bus.cfg_addr_o); end
        checks++; if (bus.cfg_data_o !== 16'h1234) begin errors++; $display("FAIL good_data got %h want 1234", bus.cfg_data_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", bus.busy_o); end
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL good_model_cycles got %0d want 0", mm - mm0); end
    endtask

    task automatic test_csum_err;
        int we0, er0, mm0;
        we0 = obs_we; er0 = obs_err; mm0 = mm;
        send_byte(8'hA5, 10); send_byte(8'h02, 10); send_byte(8'h12, 10);
        send_byte(8'h34, 10); send_byte(8'h25, 10);
        checks++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd1) begin errors++;
            $display("FAIL csum_err got err=%b code=%0d want err=1 code=1", bus.err_o, bus.err_code_o); end
        idle(3);
        checks++; if (obs_err - er0 !== 1) begin errors++; $display("FAIL csum_err_count got %0d want 1", obs_err - er0); end
        checks++; if (obs_we - we0 !== 0) begin errors++; $display("FAIL csum_we_count got %0d want 0", obs_we - we0); end
        checks++; if (bus.cfg_addr_o !== 8'h02 || bus.cfg_data_o !== 16'h1234) begin errors++;
            $display("FAIL csum_held got %h/%h want 02/1234", bus.cfg_addr_o, bus.cfg_data_o); end
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL csum_model_cycles got %0d want 0", mm - mm0); end
    endtask

    task automatic test_bad_addr;
        int we0, er0;
        we0 = obs_we; er0 = obs_err;
        send_byte(8'hA5, 4); send_byte(8'h07, 4); send_byte(8'h00, 4);
        send_byte(8'h01, 4); send_byte(8'h06, 4);
        checks++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd3) begin errors++;
            $display("FAIL badaddr got err=%b code=%0d want err=1 code=3", bus.err_o, bus.err_code_o); end
        idle(3);
        checks++; if (obs_we - we0 !== 0 || obs_err - er0 !== 1) begin errors++;
            $display("FAIL badaddr_counts got we=%0d err=%0d want we=0 err=1", obs_we - we0, obs_err - er0); end
    endtask

    task automatic test_timeout;
        int hit, mm0;
        hit = -1; mm0 = mm;
        send_byte(8'hA5, 5); send_byte(8'h01, 5);
        for (int k = 1; k <= 80; k++) begin
            idle(1);
            if (hit < 0 && bus.err_o === 1'b1) begin
                hit = k;
                checks++; if (bus.err_code_o !== 2'd2) begin errors++; $display("FAIL timeout_code got %0d want 2", bus.err_code_o); end
            end
        end
        checks++; if (hit !== TMO) begin errors++; $display("FAIL timeout_latency got %0d want %0d", hit, TMO); end
        send_byte(8'hA5, 3); send_byte(8'h01, 3); send_byte(8'hAB, 3);
        send_byte(8'hCD, 3); send_byte(8'h67, 3);
        checks++; if (bus.cfg_we_o !== 1'b1 || bus.cfg_addr_o !== 8'h01 || bus.cfg_data_o !== 16'hABCD) begin errors++;
            $display("FAIL timeout_recover got we=%b %h/%h want we=1 01/abcd", bus.cfg_we_o, bus.cfg_addr_o, bus.cfg_data_o); end
        idle(2);
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL timeout_model_cycles got %0d want 0", mm - mm0); end
    endtask

    task automatic test_byte_wins;
        int we0, er0, mm0;
        we0 = obs_we; er0 = obs_err; mm0 = mm;
        // Each byte lands exactly on the last permitted cycle.
        send_byte(8'hA5, 2); send_byte(8'h01, TMO - 1); send_byte(8'h00, TMO - 1);
        send_byte(8'h00, TMO - 1); send_byte(8'h01, TMO - 1);
        idle(2);
        checks++; if (obs_we - we0 !== 1 || obs_err - er0 !== 0) begin errors++;
            $display("FAIL byte_wins got we=%0d err=%0d want we=1 err=0", obs_we - we0, obs_err - er0); end
        // One cycle later is too late.
        send_byte(8'hA5, 2); send_byte(8'h01, TMO); idle(3);
        checks++; if (obs_err - er0 !== 1 || bus.err_code_o !== 2'd2) begin errors++;
            $display("FAIL one_late got err=%0d code=%0d want err=1 code=2", obs_err - er0, bus.err_code_o); end
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL boundary_model_cycles got %0d want 0", mm - mm0); end
    endtask

    task automatic test_garbage_sync;
        int er0, we0;
        er0 = obs_err; we0 = obs_we;
        send_byte(8'h00, 6); send_byte(8'hFF, 6);
        checks++; if (obs_err - er0 !== 0 || bus.busy_o !== 1'b0) begin errors++;
            $display("FAIL garbage_ignored got err=%0d busy=%b want 0/0", obs_err - er0, bus.busy_o); end
        send_byte(8'hA5, 6); send_byte(8'hA5, 6); send_byte(8'hA5, 6);
        send_byte(8'h00, 6); send_byte(8'hA5, 6);
        checks++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd1) begin errors++;
            $display("FAIL embedded_sync got err=%b code=%0d want err=1 code=1", bus.err_o, bus.err_code_o); end
        idle(3);
        checks++; if (obs_err - er0 !== 1 || obs_we - we0 !== 0) begin errors++;
            $display("FAIL embedded_counts got err=%0d we=%0d want 1/0", obs_err - er0, obs_we - we0); end
    endtask

    task automatic test_reset_mid;
        int er0;
        er0 = obs_err;
        send_byte(8'hA5, 3); send_byte(8'h03, 3); send_byte(8'h11, 3);
        rst = 1; @(negedge clk); rst = 0;
        checks++; if (bus.busy_o !== 1'b0 || bus.cfg_addr_o !== 8'h00 || bus.cfg_data_o !== 16'h0 ||
                      bus.err_code_o !== 2'd0 || bus.cfg_we_o !== 1'b0) begin errors++;
            $display("FAIL midrst_outputs got busy=%b %h/%h code=%0d want all 0", bus.busy_o,
                     bus.cfg_addr_o, bus.cfg_data_o, bus.err_code_o); end
        idle(TMO + 4);
        checks++; if (obs_err - er0 !== 0) begin errors++; $display("FAIL midrst_err got %0d want 0", obs_err - er0); end
        send_byte(8'hA5, 3); send_byte(8'h03, 3); send_byte(8'h11, 3);
        send_byte(8'h22, 3); send_byte(8'h30, 3);
        checks++; if (bus.cfg_we_o !== 1'b1 || bus.cfg_addr_o !== 8'h03 || bus.cfg_data_o !== 16'h1122) begin errors++;
            $display("FAIL midrst_recover got we=%b %h/%h want we=1 03/1122", bus.cfg_we_o, bus.cfg_addr_o, bus.cfg_data_o); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int we0, mm0;
        we0 = obs_we; mm0 = mm;
        for (int f = 0; f < 6; f++)
            send_frame(8'($urandom_range(0, NREGS - 1)), 8'($urandom), 8'($urandom), 0, 0);
        idle(2);
        checks++; if (obs_we - we0 !== 6) begin errors++; $display("FAIL b2b_we_count got %0d want 6", obs_we - we0); end
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL b2b_model_cycles got %0d want 0", mm - mm0); end
    endtask

    task automatic test_random;
        int we0, er0, mwe0, mer0, mm0, g;
        we0 = obs_we; er0 = obs_err; mwe0 = m_we_cnt; mer0 = m_err_cnt; mm0 = mm;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 5));
            g = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 3, TMO + 2) : $urandom_range(0, 12);
            send_frame(8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, g);
        end
        idle(TMO + 4);
        checks++; if (obs_we - we0 !== m_we_cnt - mwe0) begin errors++;
            $display("FAIL rand_we_count got %0d want %0d", obs_we - we0, m_we_cnt - mwe0); end
        checks++; if (obs_err - er0 !== m_err_cnt - mer0) begin errors++;
            $display("FAIL rand_err_count got %0d want %0d", obs_err - er0, m_err_cnt - mer0); end
        checks++; if (mm - mm0 !== 0) begin errors++; $display("FAIL rand_model_cycles got %0d want 0", mm - mm0); end
    endtask

    initial begin
        bus.rx_valid_i = 0;
        bus.rx_data_i  = 8'h00;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        mon_en = 1;
        test_reset();
        test_good_frame();
        test_csum_err();
        test_bad_addr();
        test_timeout();
        test_byte_wins();
        test_garbage_sync();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
